seq_divider_bcd: RTL

Sequential unsigned divider with binary-to-BCD conversion. It accepts a dividend and divisor on a start pulse and computes the quotient and remainder by restoring division, one bit per cycle. Each result is clamped to 99 and converted to two BCD digits. The registered digit outputs connect directly to the four-digit seven-segment display interface: quotient on the left pair of digits, remainder on the right pair.

---
 rtl/div_pkg.sv | 18 +
 rtl/bin2bcd_seq.sv | 48 ++++
 rtl/seq_divider_bcd.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and BCD constants for seq_divider_bcd
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      CONV = 2'd2
   } state_t;

   localparam int BCD_MAX        = 99;
   localparam int DIGIT_W        = 4;
   localparam int BCD_ADJ_THRESH = 5;

   function automatic logic [DIGIT_W-1:0] bcd_adjust(input logic [DIGIT_W-1:0] d);
      return (d >= DIGIT_W'(BCD_ADJ_THRESH)) ? d + DIGIT_W'(3) : d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter for a clamped 0..99 value
module bin2bcd_seq
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [6:0]         bin,
   output logic [DIGIT_W-1:0] bcd_tens,
   output logic [DIGIT_W-1:0] bcd_units
);

   logic [DATA_WIDTH-1:0]  bin_sr;
   logic [2*DIGIT_W-1:0]   bcd_sr;
   logic [2*DIGIT_W-1:0]   bcd_nx;
   logic [DIGIT_W-1:0]     units_adj;
   logic [DIGIT_W-2:0]     tens_adj;

   // The tens carry into hundreds is never set for values <= 99, so only three
   // tens bits survive the shift.
   always_comb begin
      units_adj = bcd_adjust(bcd_sr[DIGIT_W-1:0]);
      tens_adj  = bcd_sr[2*DIGIT_W-2:DIGIT_W]
                + ((bcd_sr[2*DIGIT_W-1:DIGIT_W] >= DIGIT_W'(BCD_ADJ_THRESH)) ? 3'd3 : 3'd0);
      bcd_nx    = {tens_adj, units_adj, bin_sr[DATA_WIDTH-1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_sr <= '0;
         bcd_sr <= '0;
      end else if (load) begin
         bin_sr <= DATA_WIDTH'(bin);
         bcd_sr <= '0;
      end else begin
         bin_sr <= {bin_sr[DATA_WIDTH-2:0], 1'b0};
         bcd_sr <= bcd_nx;
      end
   end

   // Outputs show the result of the step in progress so the parent can
   // capture the final digits on the same edge as the last step.
   assign bcd_tens  = bcd_nx[2*DIGIT_W-1:DIGIT_W];
   assign bcd_units = bcd_nx[DIGIT_W-1:0];

endmodule

// File: rtl/seq_divider_bcd.sv
// rtl/seq_divider_bcd.sv - restoring divider with clamped two-digit BCD quotient/remainder
module seq_divider_bcd
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DIGIT_W-1:0]    quo_out2,
   output logic [DIGIT_W-1:0]    quo_out1,
   output logic [DIGIT_W-1:0]    rem_out2,
   output logic [DIGIT_W-1:0]    rem_out1,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  ovf
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   state_t                state, state_nx;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] p_r, q_r, d_r, q_nx;
   logic [DATA_WIDTH:0]   p_sh, p_nx;
   logic [31:0]           q_wide, r_wide;
   logic [6:0]            q_c, r_c;
   logic                  clamped, last_step, accept, div_zero, conv_load, finish;
   logic [DIGIT_W-1:0]    qt, qu, rt, ru;

   assign last_step = (cnt == CW'(DATA_WIDTH - 1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      div_zero  = 1'b0;
      conv_load = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: if (start) begin
            if (divisor != '0) begin
               accept   = 1'b1;
               state_nx = DIV;
            end else begin
               div_zero = 1'b1;
            end
         end
         DIV: if (last_step) begin
            conv_load = 1'b1;
            state_nx  = CONV;
         end
         CONV: if (last_step) begin
            finish   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // One restoring step; the stored remainder always fits DATA_WIDTH bits.
   always_comb begin
      p_sh = {p_r, q_r[DATA_WIDTH-1]};
      p_nx = p_sh;
      q_nx = {q_r[DATA_WIDTH-2:0], 1'b0};
      if (p_sh >= {1'b0, d_r}) begin
         p_nx    = p_sh - {1'b0, d_r};
         q_nx[0] = 1'b1;
      end
      q_wide = 32'(q_nx);
      r_wide = 32'(p_nx);
      q_c    = (q_wide > 32'(BCD_MAX)) ? 7'(BCD_MAX) : q_wide[6:0];
      r_c    = (r_wide > 32'(BCD_MAX)) ? 7'(BCD_MAX) : r_wide[6:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         p_r     <= '0;
         q_r     <= '0;
         d_r     <= '0;
         clamped <= 1'b0;
      end else if (accept) begin
         cnt <= '0;
         p_r <= '0;
         q_r <= dividend;
         d_r <= divisor;
      end else if (state == DIV) begin
         cnt <= last_step ? '0 : cnt + CW'(1);
         p_r <= p_nx[DATA_WIDTH-1:0];
         q_r <= q_nx;
         if (conv_load)
            clamped <= (q_wide > 32'(BCD_MAX)) || (r_wide > 32'(BCD_MAX));
      end else if (state == CONV) begin
         cnt <= last_step ? '0 : cnt + CW'(1);
      end
   end

   bin2bcd_seq #(.DATA_WIDTH(DATA_WIDTH)) u_quo_bcd (
      .clk       (clk),
      .rst       (rst),
      .load      (conv_load),
      .bin       (q_c),
      .bcd_tens  (qt),
      .bcd_units (qu)
   );

   bin2bcd_seq #(.DATA_WIDTH(DATA_WIDTH)) u_rem_bcd (
      .clk       (clk),
      .rst       (rst),
      .load      (conv_load),
      .bin       (r_c),
      .bcd_tens  (rt),
      .bcd_units (ru)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quo_out2 <= '0;
         quo_out1 <= '0;
         rem_out2 <= '0;
         rem_out1 <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         done <= finish | div_zero;
         if (finish) begin
            quo_out2 <= qt;
            quo_out1 <= qu;
            rem_out2 <= rt;
            rem_out1 <= ru;
            err      <= 1'b0;
            ovf      <= clamped;
         end else if (div_zero) begin
            quo_out2 <= '0;
            quo_out1 <= '0;
            rem_out2 <= '0;
            rem_out1 <= '0;
            err      <= 1'b1;
            ovf      <= 1'b0;
         end
      end
   end

endmodule
